// File: rtl/rr_grant_sched.sv
// Round-robin scheduler: one owner of a shared resource at a time, one-hot select,
// hold while the owner keeps requesting, forced release after MAX_HOLD cycles.
module rr_grant_sched #(
  parameter int N        = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic            timeout,
  output logic [1:0]      dbg_state,
  output logic [IDXW-1:0] dbg_ptr
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q;
  logic [IDXW-1:0] ptr_q;
  logic [CW-1:0]   hold_cnt_q;
  logic [IDXW-1:0] grant_idx_q;
  logic            grant_valid_q;
  logic            timeout_q;
  logic [N-1:0]    grant_q;

  logic [IDXW-1:0] winner;
  logic [IDXW-1:0] cand;
  logic [IDXW-1:0] ptr_d;
  logic            owner_req;

  // Search from the highest offset down so the lowest offset from ptr wins;
  // N is a power of two, so index wrap is plain truncation.
  always_comb begin
    winner = ptr_q;
    cand   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr_q + IDXW'(k);
      if (req[cand]) winner = cand;
    end
  end

  assign ptr_d     = grant_idx_q + 1'b1;
  assign owner_req = req[grant_idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      grant_q       <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE, S_GAP: begin
          if (|req) begin
            grant_idx_q   <= winner;
            grant_q       <= N'(1) << winner;
            grant_valid_q <= 1'b1;
            hold_cnt_q    <= '0;
            state_q       <= S_BUSY;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_BUSY: begin
          // Normal release wins over forced release on the final cycle.
          if (!owner_req) begin
            grant_valid_q <= 1'b0;
            grant_q       <= '0;
            ptr_q         <= ptr_d;
            state_q       <= S_GAP;
          end else if (hold_cnt_q == HOLD_LAST) begin
            grant_valid_q <= 1'b0;
            grant_q       <= '0;
            timeout_q     <= 1'b1;
            ptr_q         <= ptr_d;
            state_q       <= S_GAP;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          grant_valid_q <= 1'b0;
          grant_q       <= '0;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;
  assign dbg_state   = state_q;
  assign dbg_ptr     = ptr_q;

endmodule

// File: tb/tb_rr_grant_sched.sv
// Bench for rr_grant_sched: vector table, directed corner sequences and random
// traffic checked cycle by cycle against an owner/held-count reference model.
module tb_rr_grant_sched;

  localparam int N        = 8;
  localparam int IDXW     = 3;
  localparam int MAX_HOLD = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [IDXW-1:0] grant_idx;
  logic            grant_valid;
  logic            timeout;
  logic [1:0]      dbg_state;
  logic [IDXW-1:0] dbg_ptr;

  int n_pass;
  int n_total;

  // reference model: who owns the resource and for how many cycles so far
  int m_owner;
  int m_held;
  int m_ptr;
  int m_to;

  rr_grant_sched #(.N(N), .IDXW(IDXW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout),
    .dbg_state   (dbg_state),
    .dbg_ptr     (dbg_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [7:0]   req;
    logic [7:0]   exp_grant;
    logic         exp_valid;
    logic [2:0]   exp_idx;
    logic         exp_to;
    logic [2:0]   exp_ptr;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int rr_pick(input logic [7:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [7:0] q);
    if (r) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (m_owner >= 0) begin
      if (!q[m_owner]) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1;
      end else if (m_held == MAX_HOLD) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_to = 1;
      end else begin
        m_held++;
      end
    end else if (q != 8'h00) begin
      m_owner = rr_pick(q, m_ptr);
      m_held  = 1;
    end
  endtask

  task automatic compare_model();
    chk("model_grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("model_valid", 32'(grant_valid), 32'(m_owner >= 0));
    if (m_owner >= 0) chk("model_idx", 32'(grant_idx), 32'(m_owner));
    chk("model_timeout", 32'(timeout), 32'(m_to));
    chk("model_ptr", 32'(dbg_ptr), 32'(m_ptr));
    chk("onehot0", 32'($onehot0(grant)), 32'd1);
    if (grant_valid) chk("grant_vs_idx", 32'(grant), 32'd1 << grant_idx);
    else chk("grant_zero", 32'(grant), 32'd0);
  endtask

  // driver: apply inputs away from the edge, advance one edge, check after it
  task automatic step(input logic r, input logic [7:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    model_step(r, q);
    #1;
    compare_model();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    m_owner = -1; m_held = 0; m_ptr = 0; m_to = 0;
    rst = 1'b1;
    req = 8'h00;

    // reset with all requesting, single requester, fairness after release
    vecs[0]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0};
    vecs[1]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0};
    vecs[2]  = '{1'b0, 8'h04, 8'h04, 1'b1, 3'd2, 1'b0, 3'd0};
    vecs[3]  = '{1'b0, 8'h04, 8'h04, 1'b1, 3'd2, 1'b0, 3'd0};
    vecs[4]  = '{1'b0, 8'h04, 8'h04, 1'b1, 3'd2, 1'b0, 3'd0};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 3'd3};
    vecs[6]  = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 3'd3};
    vecs[7]  = '{1'b0, 8'h0C, 8'h08, 1'b1, 3'd3, 1'b0, 3'd3};
    vecs[8]  = '{1'b0, 8'h0C, 8'h08, 1'b1, 3'd3, 1'b0, 3'd3};
    vecs[9]  = '{1'b0, 8'h04, 8'h00, 1'b0, 3'd0, 1'b0, 3'd4};
    vecs[10] = '{1'b0, 8'h04, 8'h04, 1'b1, 3'd2, 1'b0, 3'd4};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 3'd3};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, vecs[i].req);
      chk("tbl_grant", 32'(grant), 32'(vecs[i].exp_grant));
      chk("tbl_valid", 32'(grant_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid || vecs[i].rst) chk("tbl_idx", 32'(grant_idx), 32'(vecs[i].exp_idx));
      chk("tbl_timeout", 32'(timeout), 32'(vecs[i].exp_to));
      chk("tbl_ptr", 32'(dbg_ptr), 32'(vecs[i].exp_ptr));
    end

    // rotation: every owner drops for one edge, then everyone requests again
    step(1'b1, 8'h00);
    for (int k = 0; k < 9; k++) begin
      logic [7:0] g;
      step(1'b0, 8'hFF);
      g = 8'h01 << (k % 8);
      chk("rot_grant", 32'(grant), 32'(g));
      step(1'b0, 8'hFF & ~g);
      chk("rot_gap", 32'(grant), 32'd0);
    end

    // timeout: sole requester held high
    step(1'b1, 8'h00);
    step(1'b0, 8'h10);
    chk("to_first", 32'(grant), 32'h10);
    for (int c = 2; c <= MAX_HOLD; c++) begin
      step(1'b0, 8'h10);
      chk("to_hold", 32'(grant), 32'h10);
      chk("to_no_pulse", 32'(timeout), 32'd0);
    end
    step(1'b0, 8'h10);
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_gap", 32'(grant), 32'd0);
    step(1'b0, 8'h10);
    chk("to_regrant", 32'(grant), 32'h10);
    chk("to_pulse_end", 32'(timeout), 32'd0);

    // release on the final allowed cycle: normal release, no timeout
    step(1'b1, 8'h00);
    for (int c = 1; c <= MAX_HOLD; c++) step(1'b0, 8'h10);
    chk("sim_hold16", 32'(grant), 32'h10);
    step(1'b0, 8'h00);
    chk("sim_timeout", 32'(timeout), 32'd0);
    chk("sim_grant", 32'(grant), 32'd0);
    chk("sim_ptr", 32'(dbg_ptr), 32'd5);

    // reset in the middle of a grant
    step(1'b1, 8'h00);
    step(1'b0, 8'h02);
    step(1'b0, 8'h00);
    chk("mid_ptr_pre", 32'(dbg_ptr), 32'd2);
    for (int c = 1; c <= 5; c++) step(1'b0, 8'h40);
    chk("mid_held", 32'(grant), 32'h40);
    step(1'b1, 8'h40);
    chk("mid_grant", 32'(grant), 32'd0);
    chk("mid_valid", 32'(grant_valid), 32'd0);
    chk("mid_idx", 32'(grant_idx), 32'd0);
    chk("mid_timeout", 32'(timeout), 32'd0);
    chk("mid_ptr", 32'(dbg_ptr), 32'd0);
    step(1'b0, 8'h81);
    chk("mid_after", 32'(grant), 32'h01);

    // random traffic: sparse, sticky request patterns so holds and timeouts occur
    begin
      logic [7:0] cur;
      cur = 8'h00;
      for (int i = 0; i < 3000; i++) begin
        logic r;
        r = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 3) == 0) cur = 8'($urandom & $urandom);
        step(r, cur);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
